// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: state encoding and default operand width.
package gcd_pkg;

  localparam int GCD_WIDTH = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_B  = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_WAIT_B  = ST_WAIT_B,
    S_COMPUTE = ST_COMPUTE,
    S_DONE    = ST_DONE
  } gcd_state_e;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, compare/subtract step, result register and saturating
// subtraction counter for the GCD engine.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             clr,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             step,
  input  logic             latch_out,
  input  logic             latch_or,
  input  logic [WIDTH-1:0] din,
  output logic             a_zero,
  output logic             din_zero,
  output logic             a_eq_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] iter
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      a      <= '0;
      b      <= '0;
      result <= '0;
      iter   <= '0;
    end else if (clr) begin
      a      <= '0;
      b      <= '0;
      result <= '0;
      iter   <= '0;
    end else begin
      if (load_a) begin
        a    <= din;
        iter <= '0;
      end
      if (load_b)
        b <= din;
      // only the larger operand is reduced, so the subtraction never underflows
      if (step) begin
        if (a > b) begin
          a <= a - b;
          if (iter != '1) iter <= iter + WIDTH'(1);
        end else if (b > a) begin
          b <= b - a;
          if (iter != '1) iter <= iter + WIDTH'(1);
        end
      end
      if (latch_out)
        result <= latch_or ? (a | din) : a;
    end
  end

  assign a_zero   = (a == '0);
  assign din_zero = (din == '0);
  assign a_eq_b   = (a == b);

endmodule

// File: rtl/gcd_engine.sv
// GCD engine top: Enter edge detect, sequencing FSM and zero-operand flag
// around the subtract-based datapath.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | waiting for first operand (A)
// S_WAIT_B  | A captured, waiting for second operand (B)
// S_COMPUTE | one subtraction per cycle until A == B
// S_DONE    | Halt high, result valid; next Enter starts a new A
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int ST_W  = 3
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             Init,
  input  logic             Enter,
  input  logic [WIDTH-1:0] Input,
  output logic             Halt,
  output logic [WIDTH-1:0] Output,
  output logic             Busy,
  output logic [WIDTH-1:0] Iter,
  output logic             ZeroErr,
  output logic [ST_W-1:0]  State
);

  gcd_state_e state, state_nx;
  logic       enter_q;
  logic       ent_pulse;
  logic       zero_err;
  logic       load_a, load_b, step, latch_out, latch_or, set_zero;
  logic       a_zero, din_zero, a_eq_b;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)    enter_q <= 1'b0;
    else if (Init) enter_q <= 1'b0;
    else           enter_q <= Enter;
  end

  // Init discards any coincident strobe
  assign ent_pulse = Enter & ~enter_q & ~Init;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)    state <= S_IDLE;
    else if (Init) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)        zero_err <= 1'b0;
    else if (Init)     zero_err <= 1'b0;
    else if (load_a)   zero_err <= 1'b0;
    else if (set_zero) zero_err <= a_zero & din_zero;
  end

  always_comb begin
    state_nx  = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    step      = 1'b0;
    latch_out = 1'b0;
    latch_or  = 1'b0;
    set_zero  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (ent_pulse) begin
          load_a   = 1'b1;
          state_nx = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (ent_pulse) begin
          load_b = 1'b1;
          if (a_zero || din_zero) begin
            latch_out = 1'b1;
            latch_or  = 1'b1;
            set_zero  = 1'b1;
            state_nx  = S_DONE;
          end else begin
            state_nx = S_COMPUTE;
          end
        end
      end
      S_COMPUTE: begin
        if (a_eq_b) begin
          latch_out = 1'b1;
          state_nx  = S_DONE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .clr       (Init),
    .load_a    (load_a),
    .load_b    (load_b),
    .step      (step),
    .latch_out (latch_out),
    .latch_or  (latch_or),
    .din       (Input),
    .a_zero    (a_zero),
    .din_zero  (din_zero),
    .a_eq_b    (a_eq_b),
    .result    (Output),
    .iter      (Iter)
  );

  assign Halt    = (state == S_DONE);
  assign Busy    = (state == S_COMPUTE);
  assign ZeroErr = zero_err;
  assign State   = ST_W'(state);

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised next-generation GCD processor core.
- Operands are entered one at a time on a shared Input bus using Enter strobes. The core computes the GCD by repeated subtraction, then raises Halt with the result held on Output.
- New relative to the fixed 8-bit core:
  - WIDTH parameter.
  - Enter edge detection, so a held strobe captures only once.
  - Zero-operand handling with an error flag.
  - Iteration counter output.
  - Busy status.
- Sits between the operator input panel and the result display. It is also the unit the system bench drives.

Parameters:
- WIDTH, 8, operand/result width in bits (minimum 2).
- ST_W, 3, width of the State debug output.

Ports:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Init  in  1  synchronous restart to IDLE, active-high.
- Enter  in  1  operand strobe, synchronous to CLOCK; may be held high for several cycles.
- Input  in  WIDTH  operand data, sampled on the accepted Enter edge.
- Halt  out  1  high while in DONE; Output is valid.
- Output  out  WIDTH  GCD result register.
- Busy  out  1  high while in COMPUTE.
- Iter  out  WIDTH  count of subtractions in the last/current computation; saturates at all-ones.
- ZeroErr  out  1  set when both operands are 0.
- State  out  ST_W  current FSM state code (debug).

Behaviour:
- Reset (RESET low, asynchronous):
  - State=IDLE.
  - A, B, Output, Iter = 0.
  - Halt, Busy, ZeroErr = 0.
  - Enter_q = 0.
- Init high at a rising edge: same effect as reset, applied synchronously. Init overrides all other activity, including COMPUTE.
- Enter edge: ent_pulse = Enter & ~Enter_q, with Enter_q registered every cycle. Only ent_pulse is acted on; holding Enter for N cycles gives one capture.
- States (encoding 0..3): IDLE, WAIT_B, COMPUTE, DONE.
- IDLE, on ent_pulse:
  - A <= Input; Iter <= 0; ZeroErr <= 0.
  - Go to WAIT_B.
- WAIT_B, on ent_pulse:
  - B <= Input.
  - If A==0 or Input==0: Output <= A|Input; ZeroErr <= (A==0 && Input==0); go to DONE, skipping COMPUTE.
  - Otherwise go to COMPUTE.
- COMPUTE, one step per cycle:
  - A>B: A <= A-B; Iter++.
  - B>A: B <= B-A; Iter++.
  - A==B: Output <= A; go to DONE.
  - ent_pulse is ignored in COMPUTE.
  - Iter saturates at all-ones and does not wrap.
- COMPUTE latency: Halt rises k+1 edges after COMPUTE is entered, where k is the number of subtractions.
- DONE:
  - Halt=1; Output, Iter and ZeroErr hold.
  - On ent_pulse: A <= Input; Iter <= 0; ZeroErr <= 0; go to WAIT_B. Halt drops on the same edge.
  - Back-to-back operations therefore need no Init.
- Halt=(State==DONE) and Busy=(State==COMPUTE). Both are combinational from the state register, so they are glitch-free from registered state.
- Output changes only on entry to DONE, reset or Init. It is stable at every other time.
- Arithmetic is unsigned throughout. Subtraction cannot underflow, because it runs only on the larger operand.
- Worst case: (2^WIDTH-1, 1) takes 2^WIDTH-2 subtractions.
- Reset asserted mid-COMPUTE: immediate return to IDLE, outputs cleared. An Enter held high across reset release captures on the first cycle after release only if Enter_q was 0, i.e. Enter is treated as a new edge.
- Init and ent_pulse in the same cycle: Init wins and the pulse is discarded.

Decomposition:
- Package gcd_pkg:
  - State encoding localparams: ST_IDLE=0, ST_WAIT_B=1, ST_COMPUTE=2, ST_DONE=3.
  - Default WIDTH.
- One sub-module, gcd_datapath:
  - Holds the A/B registers, comparator, subtractor, Output register and saturating Iter counter.
  - Controlled by load_a, load_b, step and latch_out from the FSM in gcd_engine.
- Enter edge detection stays in the top level.

Test Plan:
1. WIDTH=8: Enter 5, then Enter 1, each held 2 cycles -> Halt=1, Output=1, Iter=4, ZeroErr=0; Halt rises 5 edges after COMPUTE entry.
2. Sequence (2,2),(4,2),(6,2),(8,2),(10,2) with no Init between -> each gives Output=2; Iter=0,1,2,3,4; Halt drops on each new first-operand capture.
3. Operands (12,18) -> Output=6, Iter=2. Operands (0,7) -> Output=7, ZeroErr=0, Iter=0, Halt on the edge after the second capture. Operands (0,0) -> Output=0, ZeroErr=1.
4. Enter held 6 cycles in IDLE with Input=9, then Input changed to 3 with Enter still high -> A=9 only, state WAIT_B. A strobe pulsed during COMPUTE for (200,1) is ignored, and the result is 1.
5. (200,1) started, Init pulsed after 20 COMPUTE cycles -> State=IDLE, Output=0, Iter=0, Halt=0. Repeat with RESET low asynchronously mid-cycle -> same values immediately, without waiting for a clock edge.
6. WIDTH=16: (65535,1) -> Output=1, Iter=65534, Busy high for exactly 65535 cycles. (65535,65535) -> Output=65535, Iter=0.
